// File: rtl/int16_block_accum_if.sv
// Sample-in / block-result-out handshake bundle for int16_block_accum.
// The master side drives samples and consumes results; the slave side is the accumulator.
interface int16_block_accum_if;
    logic                clear;
    logic                in_valid;
    logic                in_ready;
    logic signed [15:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [23:0]  out_sum;
    logic signed [15:0]  out_mean;

    modport master (
        output clear,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_mean
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_mean
    );
endinterface

// File: rtl/int16_block_accum.sv
// Sums blocks of 2^LOG2_N signed int16 samples and emits the block sum and its
// floor mean through a one-deep ready/valid result register.
module int16_block_accum #(
    parameter int LOG2_N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    int16_block_accum_if.slave    bus
);
    localparam int N     = 1 << LOG2_N;
    // A one-bit counter is kept for N = 1; it never leaves zero because every sample is final.
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic signed [23:0]  acc;
    logic [CNT_W-1:0]    cnt;
    logic signed [23:0]  sample_ext;
    logic signed [23:0]  block_sum;
    logic                accept;
    logic                last;
    logic                complete;

    logic                vld_p0;
    logic signed [23:0]  sum_p0;
    logic signed [15:0]  mean_p0;

    // Arithmetic shift floors toward negative infinity; the result always fits 16 bits.
    function automatic logic signed [15:0] floor_mean(input logic signed [23:0] s);
        return $signed(16'(s >>> LOG2_N));
    endfunction

    assign bus.in_ready = !vld_p0 || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last         = (cnt == CNT_LAST);
    assign complete     = accept && last && !bus.clear;
    assign sample_ext   = {{8{bus.in_data[15]}}, bus.in_data};
    assign block_sum    = acc + sample_ext;

    // Stage p0: accumulate, and on the final sample register the block result
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            vld_p0  <= 1'b0;
            sum_p0  <= '0;
            mean_p0 <= '0;
        end else begin
            if (bus.clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= block_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end

            // A block finishing on the same edge as a consume replaces the old result.
            if (complete) begin
                vld_p0  <= 1'b1;
                sum_p0  <= block_sum;
                mean_p0 <= floor_mean(block_sum);
            end else if (vld_p0 && bus.out_ready) begin
                vld_p0  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.out_sum   = sum_p0;
    assign bus.out_mean  = mean_p0;
endmodule

// File: tb/tb_int16_block_accum.sv
// Directed and random checks of int16_block_accum at N = 1, 4 and 16 against a
// sample-list reference model that sums whole blocks and floor-divides.
module tb_int16_block_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic                clear    = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [15:0]  in_data  = '0;
    logic                out_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int16_block_accum_if b0 ();
    int16_block_accum_if b2 ();
    int16_block_accum_if b4 ();

    assign b0.clear = clear;  assign b0.in_valid = in_valid;
    assign b0.in_data = in_data;  assign b0.out_ready = out_ready;
    assign b2.clear = clear;  assign b2.in_valid = in_valid;
    assign b2.in_data = in_data;  assign b2.out_ready = out_ready;
    assign b4.clear = clear;  assign b4.in_valid = in_valid;
    assign b4.in_data = in_data;  assign b4.out_ready = out_ready;

    int16_block_accum #(.LOG2_N(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    int16_block_accum #(.LOG2_N(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    int16_block_accum #(.LOG2_N(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    // Reference model: collect accepted samples, total them when a block fills up.
    int  nk [3] = '{1, 4, 16};
    int  m_buf [3][256];
    int  m_cnt [3];
    bit  m_vld [3];
    int  m_sum [3];
    int  m_mean [3];

    function automatic int floor_div(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    always @(posedge clk) begin
        bit take;
        bit fin;
        int tot;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_vld[k] = 1'b0; m_sum[k] = 0; m_mean[k] = 0; m_cnt[k] = 0;
            end else begin
                take = in_valid && (!m_vld[k] || out_ready);
                fin  = 1'b0;
                if (clear) begin
                    m_cnt[k] = 0;
                end else if (take) begin
                    m_buf[k][m_cnt[k]] = int'(in_data);
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == nk[k]) begin
                        tot = 0;
                        for (int i = 0; i < nk[k]; i++) tot += m_buf[k][i];
                        m_sum[k]  = tot;
                        m_mean[k] = floor_div(tot, nk[k]);
                        m_cnt[k]  = 0;
                        fin = 1'b1;
                    end
                end
                if (fin) m_vld[k] = 1'b1;
                else if (m_vld[k] && out_ready) m_vld[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string tag, input int k, input logic v, input logic r,
                              input logic signed [23:0] s, input logic signed [15:0] m);
        int si;
        int mi;
        si = s;
        mi = m;
        chk({tag, ".out_valid"}, int'(v), int'(m_vld[k]));
        chk({tag, ".in_ready"}, int'(r), int'(!m_vld[k] || out_ready));
        if (m_vld[k]) begin
            chk({tag, ".out_sum"}, si, m_sum[k]);
            chk({tag, ".out_mean"}, mi, m_mean[k]);
        end
    endtask

    task automatic check_all();
        check_inst("n1",  0, b0.out_valid, b0.in_ready, b0.out_sum, b0.out_mean);
        check_inst("n4",  1, b2.out_valid, b2.in_ready, b2.out_sum, b2.out_mean);
        check_inst("n16", 2, b4.out_valid, b4.in_ready, b4.out_sum, b4.out_mean);
    endtask

    task automatic cyc(input bit v, input int d, input bit cl, input bit ordy);
        in_valid  = v;
        in_data   = 16'(d);
        clear     = cl;
        out_ready = ordy;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int si;
        // Reset held two cycles while samples are offered
        rst = 1'b1;
        cyc(1, 5, 0, 1);
        cyc(1, 5, 0, 1);
        chk("rst.out_valid", int'(b2.out_valid), 0);
        si = b2.out_sum;
        chk("rst.out_sum", si, 0);
        si = b2.out_mean;
        chk("rst.out_mean", si, 0);
        chk("rst.in_ready", int'(b2.in_ready), 1);
        rst = 1'b0;

        // Basic block 1, 2, 3, 6
        cyc(1, 1, 0, 1);
        cyc(1, 2, 0, 1);
        cyc(1, 3, 0, 1);
        chk("basic.early_valid", int'(b2.out_valid), 0);
        cyc(1, 6, 0, 1);
        chk("basic.out_valid", int'(b2.out_valid), 1);
        si = b2.out_sum;  chk("basic.out_sum", si, 12);
        si = b2.out_mean; chk("basic.out_mean", si, 3);
        cyc(0, 0, 0, 1);
        chk("basic.one_cycle", int'(b2.out_valid), 0);

        // Floor rounding of a small negative sum
        cyc(1, -1, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        si = b2.out_sum;  chk("floor.out_sum", si, -1);
        si = b2.out_mean; chk("floor.out_mean", si, -1);

        // Full-scale blocks at N = 16
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 16; i++) cyc(1, 16'h8000, 0, 1);
        si = b4.out_sum;  chk("ext_neg.out_sum", si, -524288);
        si = b4.out_mean; chk("ext_neg.out_mean", si, -32768);
        for (int i = 0; i < 16; i++) cyc(1, 16'h7FFF, 0, 1);
        si = b4.out_sum;  chk("ext_pos.out_sum", si, 524272);
        si = b4.out_mean; chk("ext_pos.out_mean", si, 32767);

        // Backpressure: result held while the consumer stalls
        cyc(1, 10, 0, 1);
        cyc(1, 20, 0, 1);
        cyc(1, 30, 0, 1);
        cyc(1, 40, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 99, 0, 0);
            chk("bp.in_ready", int'(b2.in_ready), 0);
            chk("bp.out_valid", int'(b2.out_valid), 1);
            si = b2.out_sum;  chk("bp.out_sum", si, 100);
            si = b2.out_mean; chk("bp.out_mean", si, 25);
        end
        cyc(1, 1, 0, 1);
        chk("bp.n1_replace_valid", int'(b0.out_valid), 1);
        si = b0.out_sum; chk("bp.n1_replace_sum", si, 1);
        cyc(1, 2, 0, 1);
        cyc(1, 3, 0, 1);
        cyc(1, 4, 0, 1);
        si = b2.out_sum;  chk("bp.next_sum", si, 10);
        si = b2.out_mean; chk("bp.next_mean", si, 2);

        // Clear discards the partial block and the sample offered with it
        cyc(1, 5, 0, 1);
        cyc(1, 5, 0, 1);
        cyc(1, 9, 1, 1);
        chk("clr.out_valid", int'(b2.out_valid), 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
        si = b2.out_sum;  chk("clr.out_sum", si, 4);
        si = b2.out_mean; chk("clr.out_mean", si, 1);

        // Reset mid-block with a pending stalled result
        cyc(1, 7, 0, 1);
        cyc(1, 7, 0, 0);
        rst = 1'b1;
        cyc(1, 7, 0, 0);
        rst = 1'b0;
        chk("mid_rst.in_ready", int'(b2.in_ready), 1);
        chk("mid_rst.out_valid", int'(b4.out_valid), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc(($urandom_range(0, 9) < 7), int'($urandom), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 9) < 6));
        end
        rst = 1'b0;
        for (int i = 0; i < 64; i++) cyc(1, int'($urandom), 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
